// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny frame sequencer and pixel pipeline.
package canny_pkg;
  localparam int PIX_CNT_W = 32;
  localparam int DIM_W     = 16;
  localparam int IL_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    CTRL,
    STREAM,
    FLUSH
  } seq_state_e;

  // Two line buffers plus the 3-tap window register chain.
  function automatic int canny_default_latency(input int width);
    return 2 * width + 3;
  endfunction
endpackage

// File: rtl/canny_frame_sequencer_if.sv
// Handshake/bus bundle between the sequencer, the VIP wrapper and the pixel pipeline.
// Optional CANNY_SEQ_PERF_EN adds the performance-counter signals.
interface canny_frame_sequencer_if;
  import canny_pkg::*;

  logic                 vip_ctrl_valid;
  logic [DIM_W-1:0]     width_in;
  logic [DIM_W-1:0]     height_in;
  logic [IL_W-1:0]      interlaced_in;
  logic                 end_of_video;
  logic                 stall_in;
  logic                 stall_out;
  logic                 vip_ctrl_busy;
  logic                 read;
  logic                 write;
  logic                 vip_ctrl_send;
  logic [DIM_W-1:0]     width_out;
  logic [DIM_W-1:0]     height_out;
  logic [IL_W-1:0]      interlaced_out;
  logic                 end_of_video_out;
  logic                 dp_advance;
  logic                 dp_sof;
  logic [DIM_W-1:0]     in_col;
  logic [DIM_W-1:0]     in_row;
  logic                 busy;
`ifdef CANNY_SEQ_PERF_EN
  logic [DIM_W-1:0]     frame_cnt;
  logic [PIX_CNT_W-1:0] in_stall_cycles;
  logic [PIX_CNT_W-1:0] out_stall_cycles;
`endif

  modport master (
    input  vip_ctrl_valid, width_in, height_in, interlaced_in, end_of_video,
    input  stall_in, stall_out, vip_ctrl_busy,
    output read, write, vip_ctrl_send, width_out, height_out, interlaced_out,
    output end_of_video_out, dp_advance, dp_sof, in_col, in_row, busy
`ifdef CANNY_SEQ_PERF_EN
    , output frame_cnt, in_stall_cycles, out_stall_cycles
`endif
  );

  modport slave (
    output vip_ctrl_valid, width_in, height_in, interlaced_in, end_of_video,
    output stall_in, stall_out, vip_ctrl_busy,
    input  read, write, vip_ctrl_send, width_out, height_out, interlaced_out,
    input  end_of_video_out, dp_advance, dp_sof, in_col, in_row, busy
`ifdef CANNY_SEQ_PERF_EN
    , input frame_cnt, in_stall_cycles, out_stall_cycles
`endif
  );
endinterface

// File: rtl/canny_pos_counter.sv
// Column/row position of the pixel being read; column wraps at a runtime frame width.
module canny_pos_counter
  import canny_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [DIM_W-1:0] width_i,
  output logic [DIM_W-1:0] col_o,
  output logic [DIM_W-1:0] row_o
);
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (inc_i) begin
      if (col_q == width_i - DIM_W'(1)) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;
endmodule

// File: rtl/canny_frame_sequencer.sv
// Frame controller for the Canny datapath: control-packet latch, lockstep advance, latency flush.
// Optional CANNY_SEQ_PERF_EN adds frame and stall counters.
module canny_frame_sequencer
  import canny_pkg::*;
#(
  parameter int WIDTH   = 1280,
  parameter int HEIGHT  = 720,
  parameter int LATENCY = canny_default_latency(WIDTH)
) (
  input logic                     clk,
  input logic                     rst,
  canny_frame_sequencer_if.master bus
);
  localparam logic [PIX_CNT_W-1:0] LAT_C   = PIX_CNT_W'(LATENCY);
  localparam logic [PIX_CNT_W-1:0] CNT_ONE = PIX_CNT_W'(1);

  if (LATENCY < 1 || WIDTH < 1 || HEIGHT < 1 || WIDTH > 65535 || HEIGHT > 65535) begin : g_bad_cfg
    $error("canny_frame_sequencer: WIDTH/HEIGHT must fit 16 bits and LATENCY must be >= 1");
  end

  seq_state_e           state_q;
  logic [PIX_CNT_W-1:0] in_cnt_q, out_cnt_q, fill_cnt_q;
  logic [PIX_CNT_W-1:0] in_cnt_d, out_cnt_d, fill_cnt_d;
  logic [PIX_CNT_W-1:0] in_target_q, out_target_q, frame_total;
  logic [DIM_W-1:0]     width_q, height_q;
  logic [IL_W-1:0]      interlaced_q;
  logic                 send_q, busy_q;
  logic                 running, need_in, need_out, advance, rd, wr;
  logic                 last_rd, last_wr, start, pos_clr;

  // Lockstep advance: one shift moves both the input and output ends of the pipeline.
  assign running  = (state_q == STREAM) || (state_q == FLUSH);
  assign need_in  = (state_q == STREAM) && (in_cnt_q < in_target_q);
  assign need_out = (fill_cnt_q == LAT_C);
  assign advance  = running && (!need_in || !bus.stall_in) && (!need_out || !bus.stall_out);
  assign rd       = advance && need_in;
  assign wr       = advance && need_out;
  assign last_rd  = rd && (in_cnt_q == in_target_q - CNT_ONE);
  assign last_wr  = wr && (state_q == FLUSH) && (out_cnt_q == out_target_q - CNT_ONE);
  assign start    = (state_q == IDLE) && bus.vip_ctrl_valid &&
                    (bus.width_in != '0) && (bus.height_in != '0);
  assign pos_clr  = (state_q == CTRL) && !bus.vip_ctrl_busy;

  assign frame_total = PIX_CNT_W'(bus.width_in) * PIX_CNT_W'(bus.height_in);
  assign in_cnt_d    = rd ? in_cnt_q + CNT_ONE : in_cnt_q;
  assign out_cnt_d   = wr ? out_cnt_q + CNT_ONE : out_cnt_q;
  assign fill_cnt_d  = (advance && !need_out) ? fill_cnt_q + CNT_ONE : fill_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      fill_cnt_q   <= '0;
      in_target_q  <= '0;
      out_target_q <= '0;
      width_q      <= '0;
      height_q     <= '0;
      interlaced_q <= '0;
      send_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      send_q     <= 1'b0;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      case (state_q)
        IDLE: begin
          if (bus.vip_ctrl_valid) begin
            width_q      <= bus.width_in;
            height_q     <= bus.height_in;
            interlaced_q <= bus.interlaced_in;
            in_target_q  <= frame_total;
            out_target_q <= frame_total;
          end
          if (start) begin
            state_q    <= CTRL;
            busy_q     <= 1'b1;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            fill_cnt_q <= '0;
          end
        end
        CTRL: begin
          if (!bus.vip_ctrl_busy) begin
            send_q  <= 1'b1;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (last_rd) begin
            state_q <= FLUSH;
          end else if (rd && bus.end_of_video) begin
            // Short field: only the pixels actually read will come out.
            in_target_q  <= in_cnt_d;
            out_target_q <= in_cnt_d;
            state_q      <= FLUSH;
          end
        end
        FLUSH: begin
          if (last_wr) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  canny_pos_counter u_pos (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (pos_clr),
    .inc_i   (rd),
    .width_i (width_q),
    .col_o   (bus.in_col),
    .row_o   (bus.in_row)
  );

  assign bus.read             = rd;
  assign bus.write            = wr;
  assign bus.dp_advance       = advance;
  assign bus.dp_sof           = rd && (in_cnt_q == '0);
  assign bus.end_of_video_out = last_wr;
  assign bus.vip_ctrl_send    = send_q;
  assign bus.width_out        = width_q;
  assign bus.height_out       = height_q;
  assign bus.interlaced_out   = interlaced_q;
  assign bus.busy             = busy_q;

`ifdef CANNY_SEQ_PERF_EN
  logic [DIM_W-1:0]     frame_cnt_q;
  logic [PIX_CNT_W-1:0] in_stall_q, out_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      in_stall_q  <= '0;
      out_stall_q <= '0;
    end else begin
      if (last_wr) begin
        frame_cnt_q <= frame_cnt_q + DIM_W'(1);
      end
      if (start) begin
        in_stall_q  <= '0;
        out_stall_q <= '0;
      end else begin
        if ((state_q == STREAM) && need_in && bus.stall_in && (in_stall_q != '1)) begin
          in_stall_q <= in_stall_q + CNT_ONE;
        end
        if (running && need_out && bus.stall_out && (out_stall_q != '1)) begin
          out_stall_q <= out_stall_q + CNT_ONE;
        end
      end
    end
  end

  assign bus.frame_cnt        = frame_cnt_q;
  assign bus.in_stall_cycles  = in_stall_q;
  assign bus.out_stall_cycles = out_stall_q;
`endif
endmodule

// File: doc/canny_frame_sequencer.md
# canny_frame_sequencer

Frame-level controller for the Canny edge-detection datapath, between the VIP flow-control wrapper and the pixel pipeline. It latches frame dimensions from each control packet and forwards them to the encoder. It drives the wrapper's read/write handshake and a single pipeline-advance enable, then flushes the pipeline's fixed pixel latency at end of frame. The datapath therefore contains no frame or handshake logic.

## Interface
- WIDTH, 1280: nominal frame width; sizes the counters.
- HEIGHT, 720: nominal frame height.
- LATENCY, 2*1280+3: number of pipeline advances between a pixel entering and its result leaving. Must be ≥1.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- vip_ctrl_valid  in  1  a new control packet's dimensions are valid.
- width_in / height_in  in  16  dimensions from the decoder.
- interlaced_in  in  4  interlace field from the decoder.
- end_of_video  in  1  the decoder's current input beat is the last of the field.
- stall_in  in  1  no input pixel available this cycle.
- stall_out  in  1  the output side cannot accept a pixel this cycle.
- vip_ctrl_busy  in  1  the encoder is still emitting the previous control packet.
- read  out  1  consume the input pixel this cycle.
- write  out  1  output pixel is valid this cycle.
- vip_ctrl_send  out  1  one-cycle request to the encoder to emit a control packet.
- width_out / height_out  out  16  latched dimensions.
- interlaced_out  out  4  latched interlace field.
- end_of_video_out  out  1  qualifies the final write of the frame.
- dp_advance  out  1  pipeline shift enable.
- dp_sof  out  1  first read of the frame.
- in_col / in_row  out  16  position of the pixel currently being read (border handling).
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, CTRL, STREAM, FLUSH.
- IDLE:
  - On vip_ctrl_valid, latch width/height/interlaced and register total = width_in*height_in (32-bit unsigned, full product).
  - If either dimension is 0, stay in IDLE and send nothing.
  - Otherwise go to CTRL.
- CTRL: assert vip_ctrl_send for exactly one cycle, in the first cycle with vip_ctrl_busy=0, then go to STREAM.
- Datapath terms:
  - need_in = (STREAM) && in_cnt < in_target, where in_target = total.
  - need_out = fill_cnt == LATENCY.
  - advance = (STREAM||FLUSH) && (!need_in || !stall_in) && (!need_out || !stall_out).
  - read = advance && need_in; write = advance && need_out; dp_advance = advance.
- fill_cnt increments on each advance, saturating at LATENCY.
- In FLUSH, advances continue without reads (bubbles) until out_cnt reaches out_target.
- in_col/in_row:
  - in_col increments on read and wraps at width to 0, which increments in_row.
  - Both are cleared on entry to STREAM.
- STREAM → FLUSH when the read of pixel in_target-1 completes.
- Early end_of_video, i.e. read together with end_of_video before pixel total-1:
  - in_target is truncated to in_cnt+1 and out_target to the same value.
  - The state goes to FLUSH.
- FLUSH → IDLE on the write that makes out_cnt = out_target. end_of_video_out=1 on that write only.
- A vip_ctrl_valid arriving outside IDLE is ignored; the latched dimensions are held for the whole frame.
- fill_cnt, in_cnt and out_cnt are cleared on IDLE→CTRL.

## Timing
- read, write, dp_advance, dp_sof and end_of_video_out are combinational from registered state plus stall_in/stall_out. There is no added cycle.
- All other outputs are registered.
- Reset values: state IDLE; all counters 0; width/height/interlaced_out 0; every output 0. busy=0.
- Reset asserted mid-frame aborts at the next edge; no flush occurs.
- First write occurs on advance number LATENCY+1 of the frame.
- Simultaneous stall_in=1 and need_out=1 in STREAM: no advance, so the output waits for input. This is intentional; the pipeline is lockstep.
- LATENCY ≥ total: the whole output is produced in FLUSH.

## Configuration
- CANNY_SEQ_PERF_EN defined adds three outputs:
  - frame_cnt (16): completed frames, wraps.
  - in_stall_cycles (32): cycles in STREAM with need_in && stall_in, saturating, cleared on entry to CTRL.
  - out_stall_cycles (32): cycles with need_out && stall_out, saturating, cleared on entry to CTRL.
- Without the macro these ports and counters do not exist. Core behaviour is identical either way.

## Structure
- Shared package canny_pkg holds:
  - the state enum (IDLE/CTRL/STREAM/FLUSH);
  - PIX_CNT_W=32 and DIM_W=16;
  - the default LATENCY formula shared with the pipeline.
- One sub-module, canny_pos_counter: the col/row counter with wrap at a runtime width.

## Test plan
- 4×3 frame, LATENCY=5, no stalls:
  - 1 vip_ctrl_send; 12 reads on consecutive cycles; first write on advance 6.
  - 12 writes total; end_of_video_out only on the 12th write; back in IDLE.
- Same frame with stall_out=1 for 3 cycles mid-stream: read, write and dp_advance are all 0 during the stall; counts still 12/12.
- vip_ctrl_busy held for 4 cycles in CTRL: vip_ctrl_send pulses once, in the cycle after busy drops.
- 4×3 frame with end_of_video on read 7: writes stop at 7; end_of_video_out is on write 7.
- Zero-width control packet: no send, no reads, busy stays 0. rst asserted during FLUSH: all outputs 0 at the next edge.
- Second vip_ctrl_valid (8×2) during STREAM: ignored. After IDLE, a new packet gives width_out=8, height_out=2, and 16 writes.
